video_pixel_out: RTL and testbench
==================================

# video_pixel_out

Consumes the CRTC's refresh timing (ma, ra, de, h_sync, v_sync) and produces the serial video stream. For each character cell it fetches the screen code from video RAM, then the glyph row from the character ROM, and shifts 8 pixels out MSB-first. Syncs and display enable are delayed by exactly one character time so they stay aligned with the pixels. It sits between the CRTC, the VRAM/char-ROM bus arbiter and the video DAC/output pins.

## Interface
- CHAR_ROWS, 8, number of scan lines per row that carry glyph data; rows with `ra_i >= CHAR_ROWS` are spacing lines.
- clk_i  in  1  system clock (16 MHz).
- reset_i  in  1  asynchronous, active-high reset.
- cclk_en_i  in  1  character clock enable, one clk_i pulse per 1 MHz; always coincides with a pixel_en_i pulse.
- pixel_en_i  in  1  pixel clock enable, 8 pulses per character.
- de_i  in  1  CRTC display enable.
- h_sync_i  in  1  CRTC horizontal sync.
- v_sync_i  in  1  CRTC vertical sync.
- ma_i  in  14  CRTC refresh address.
- ra_i  in  5  CRTC raster address.
- graphic_i  in  1  character set select (char ROM A10).
- vram_req_o  out  1  VRAM read request, level.
- vram_addr_o  out  14  VRAM address.
- vram_valid_i  in  1  one-cycle pulse; vram_data_i is valid in this cycle.
- vram_data_i  in  8  screen code.
- rom_req_o  out  1  char ROM read request, level.
- rom_addr_o  out  11  {graphic, code[6:0], ra[2:0]}.
- rom_valid_i  in  1  one-cycle pulse; rom_data_i is valid in this cycle.
- rom_data_i  in  8  glyph row, bit 7 = leftmost pixel.
- video_o  out  1  pixel output, 1 = lit.
- h_sync_o, v_sync_o, de_o  out  1 each  inputs delayed by one character.
- underrun_o  out  1  one-cycle pulse when a fetch misses its deadline.

## Operation
- FSM states: IDLE, FETCH_CHAR, FETCH_GLYPH, DONE.
- On cclk_en_i, in this order:
  - Load the shifter from the pending byte.
  - Copy stage-1 de/h_sync/v_sync to the outputs.
  - Capture de_i, h_sync_i, v_sync_i, ma_i, ra_i and graphic_i into stage 1.
  - If de_i = 1, go to FETCH_CHAR. Otherwise go to IDLE with pending = 0x00.
- FETCH_CHAR:
  - vram_req_o = 1 and vram_addr_o = captured ma.
  - On vram_valid_i, latch the code; rev = code[7].
  - If the captured ra < CHAR_ROWS, go to FETCH_GLYPH. Otherwise set pending = {8{rev}} and go to DONE.
- FETCH_GLYPH:
  - rom_req_o = 1 and rom_addr_o = {graphic, code[6:0], ra[2:0]}.
  - On rom_valid_i, set pending = rom_data_i ^ {8{rev}} and go to DONE.
- DONE holds pending until the next cclk_en_i.
- Missed deadline: cclk_en_i arriving in FETCH_CHAR or FETCH_GLYPH:
  - Load 0x00 into the shifter instead of pending.
  - Pulse underrun_o for one cycle.
  - Drop the request (req low for at least that cycle), then proceed with the new capture.
  - The arbiter discards any in-flight read when req falls.
- Valid pulses outside the matching FETCH state are ignored.
- Shifter:
  - cclk_en_i loads it. When both enables are high in the same cycle, the load wins.
  - Each later pixel_en_i shifts left, filling with 0.
  - video_o = shift[7] & de_o.
- Address outputs hold their last value when req is low.

## Timing
- Reset: all outputs 0, shifter 0, pending 0, stage-1 registers 0, state IDLE.
- Reset mid-fetch aborts immediately: req outputs go low asynchronously.
- Latency: inputs sampled at cclk_en edge N appear on h_sync_o/v_sync_o/de_o, and their pixels on video_o, starting the clock after edge N+1. That is 16 clk_i cycles at nominal rates, identical for syncs and pixels.
- Fetch budget: 15 clk_i cycles from entering FETCH_CHAR to rom_valid_i, since both reads must complete before the next cclk_en_i.
- A valid pulse in the same cycle as cclk_en_i counts as missed (underrun).
- Requests rise the cycle after cclk_en_i. rom_req_o rises the cycle after vram_valid_i.
- Pixel order: the first pixel after a load is bit 7. Bit 0 is shown for the last pixel_en period before the next cclk_en_i.

## Structure
- Shared package video_pkg: FSM state enum, CHAR_ROWS default, BLANK_BYTE = 8'h00.
- Sub-module video_shifter: 8-bit load/shift register with load-priority and the de gate.
- The FSM and delay registers live in the top module.

## Test plan
- Code 0x01, ROM row 0x3C, ra=2, de=1, graphic=0 → rom_addr_o = 0x00A. Next character period video_o = 0,0,1,1,1,1,0,0.
- Code 0x81 (reverse), same ROM row → pixels 1,1,0,0,0,0,1,1.
- ra=9, code 0x81 → no rom_req_o; video_o all 1s. Same with code 0x01 → all 0s.
- de_i=0 → no requests; video_o = 0. h_sync_o/v_sync_o follow inputs exactly 16 clocks later.
- rom_valid_i withheld past the next cclk_en_i → underrun_o pulses once, that cell's pixels are 0, and the following cell renders normally.
- reset_i asserted during FETCH_GLYPH → rom_req_o low immediately. After release: IDLE, all outputs 0, and the first cclk_en_i with de=1 starts a clean fetch.

Source files
------------

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pkg
// Brief    : Shared types and constants for the serial video pixel path.
// Revision : 1.0
// ============================================================================
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_FETCH_CHAR  = 2'd1,
    ST_FETCH_GLYPH = 2'd2,
    ST_DONE        = 2'd3
  } state_e;

  localparam int unsigned CHAR_ROWS_DEFAULT = 8;
  localparam logic [7:0]  BLANK_BYTE        = 8'h00;

  function automatic logic [7:0] rev_mask(input logic rev);
    return {8{rev}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_pixel_out_if.sv
`default_nettype none
// ============================================================================
// Module   : video_pixel_out_if
// Brief    : VRAM and character-ROM read ports between pixel output and arbiter.
// Revision : 1.0
// ============================================================================
interface video_pixel_out_if;

  logic        vram_req;
  logic [13:0] vram_addr;
  logic        vram_valid;
  logic [7:0]  vram_data;
  logic        rom_req;
  logic [10:0] rom_addr;
  logic        rom_valid;
  logic [7:0]  rom_data;

  modport master (
    output vram_req, vram_addr, rom_req, rom_addr,
    input  vram_valid, vram_data, rom_valid, rom_data
  );

  modport slave (
    input  vram_req, vram_addr, rom_req, rom_addr,
    output vram_valid, vram_data, rom_valid, rom_data
  );

endinterface
`default_nettype wire

// File: rtl/video_shifter.sv
`default_nettype none
// ============================================================================
// Module   : video_shifter
// Brief    : 8-bit pixel shifter, load beats shift, output gated by display enable.
// Revision : 1.0
// ============================================================================
module video_shifter
  import video_pkg::*;
(
  input  wire logic       clk_i,
  input  wire logic       reset_i,
  input  wire logic       load_i,
  input  wire logic       shift_i,
  input  wire logic [7:0] load_data_i,
  input  wire logic       de_i,
  output logic            video_o
);

  logic [7:0] shift_q;
  logic [7:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = load_data_i;
    end else if (shift_i) begin
      shift_d = {shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q <= BLANK_BYTE;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign video_o = shift_q[7] & de_i;

endmodule
`default_nettype wire

// File: rtl/video_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : video_pixel_out
// Brief    : Fetches screen code and glyph row per character cell and serialises
//            pixels, with syncs/enable delayed one character to stay aligned.
// Revision : 1.0
// ============================================================================
module video_pixel_out
  import video_pkg::*;
#(
  parameter int unsigned CHAR_ROWS = CHAR_ROWS_DEFAULT
) (
  input  wire logic        clk_i,
  input  wire logic        reset_i,
  input  wire logic        cclk_en_i,
  input  wire logic        pixel_en_i,
  input  wire logic        de_i,
  input  wire logic        h_sync_i,
  input  wire logic        v_sync_i,
  input  wire logic [13:0] ma_i,
  input  wire logic [4:0]  ra_i,
  input  wire logic        graphic_i,
  video_pixel_out_if.master mem,
  output logic             video_o,
  output logic             h_sync_o,
  output logic             v_sync_o,
  output logic             de_o,
  output logic             underrun_o
);

  localparam logic [5:0] ROW_LIMIT = 6'(CHAR_ROWS);

  state_e      state_q, state_d;
  logic        de_s1_q, de_s1_d;
  logic        hs_s1_q, hs_s1_d;
  logic        vs_s1_q, vs_s1_d;
  logic [4:0]  ra_s1_q, ra_s1_d;
  logic        gfx_s1_q, gfx_s1_d;
  logic        de_out_q, de_out_d;
  logic        hs_out_q, hs_out_d;
  logic        vs_out_q, vs_out_d;
  logic        rev_q, rev_d;
  logic [7:0]  pending_q, pending_d;
  logic        vram_req_q, vram_req_d;
  logic [13:0] vram_addr_q, vram_addr_d;
  logic        rom_req_q, rom_req_d;
  logic [10:0] rom_addr_q, rom_addr_d;
  logic        underrun_q, underrun_d;
  logic        miss;
  logic        glyph_row;
  logic [7:0]  load_data;

  assign glyph_row = ({1'b0, ra_s1_q} < ROW_LIMIT);

  always_comb begin
    state_d     = state_q;
    de_s1_d     = de_s1_q;
    hs_s1_d     = hs_s1_q;
    vs_s1_d     = vs_s1_q;
    ra_s1_d     = ra_s1_q;
    gfx_s1_d    = gfx_s1_q;
    de_out_d    = de_out_q;
    hs_out_d    = hs_out_q;
    vs_out_d    = vs_out_q;
    rev_d       = rev_q;
    pending_d   = pending_q;
    vram_req_d  = vram_req_q;
    vram_addr_d = vram_addr_q;
    rom_req_d   = rom_req_q;
    rom_addr_d  = rom_addr_q;
    underrun_d  = 1'b0;
    miss        = 1'b0;
    load_data   = pending_q;

    if (cclk_en_i) begin
      // A valid in the same cycle as the character clock is already too late.
      miss       = (state_q == ST_FETCH_CHAR) || (state_q == ST_FETCH_GLYPH);
      underrun_d = miss;
      load_data  = miss ? BLANK_BYTE : pending_q;
      de_out_d   = de_s1_q;
      hs_out_d   = hs_s1_q;
      vs_out_d   = vs_s1_q;
      de_s1_d    = de_i;
      hs_s1_d    = h_sync_i;
      vs_s1_d    = v_sync_i;
      ra_s1_d    = ra_i;
      gfx_s1_d   = graphic_i;
      pending_d  = BLANK_BYTE;
      rom_req_d  = 1'b0;
      vram_req_d = de_i & ~miss;
      if (de_i) begin
        state_d     = ST_FETCH_CHAR;
        vram_addr_d = ma_i;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_FETCH_CHAR: begin
          // Re-raise the request after an underrun forced it low for a cycle.
          if (!vram_req_q) begin
            vram_req_d = 1'b1;
          end else if (mem.vram_valid) begin
            vram_req_d = 1'b0;
            rev_d      = mem.vram_data[7];
            if (glyph_row) begin
              state_d    = ST_FETCH_GLYPH;
              rom_req_d  = 1'b1;
              rom_addr_d = {gfx_s1_q, mem.vram_data[6:0], ra_s1_q[2:0]};
            end else begin
              state_d   = ST_DONE;
              pending_d = rev_mask(mem.vram_data[7]);
            end
          end
        end
        ST_FETCH_GLYPH: begin
          if (rom_req_q && mem.rom_valid) begin
            state_d   = ST_DONE;
            rom_req_d = 1'b0;
            pending_d = mem.rom_data ^ rev_mask(rev_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      de_s1_q     <= 1'b0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      ra_s1_q     <= '0;
      gfx_s1_q    <= 1'b0;
      de_out_q    <= 1'b0;
      hs_out_q    <= 1'b0;
      vs_out_q    <= 1'b0;
      rev_q       <= 1'b0;
      pending_q   <= BLANK_BYTE;
      vram_req_q  <= 1'b0;
      vram_addr_q <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      de_s1_q     <= de_s1_d;
      hs_s1_q     <= hs_s1_d;
      vs_s1_q     <= vs_s1_d;
      ra_s1_q     <= ra_s1_d;
      gfx_s1_q    <= gfx_s1_d;
      de_out_q    <= de_out_d;
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
      rev_q       <= rev_d;
      pending_q   <= pending_d;
      vram_req_q  <= vram_req_d;
      vram_addr_q <= vram_addr_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
      underrun_q  <= underrun_d;
    end
  end

  video_shifter u_shifter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (cclk_en_i),
    .shift_i     (pixel_en_i),
    .load_data_i (load_data),
    .de_i        (de_out_q),
    .video_o     (video_o)
  );

  assign mem.vram_req  = vram_req_q;
  assign mem.vram_addr = vram_addr_q;
  assign mem.rom_req   = rom_req_q;
  assign mem.rom_addr  = rom_addr_q;
  assign h_sync_o      = hs_out_q;
  assign v_sync_o      = vs_out_q;
  assign de_o          = de_out_q;
  assign underrun_o    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_video_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_pixel_out
// Brief    : Directed bench for video_pixel_out with a small VRAM/ROM responder.
// Revision : 1.0
// ============================================================================
module tb_video_pixel_out;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cclk_en_i, pixel_en_i;
  logic        de_i, h_sync_i, v_sync_i, graphic_i;
  logic [13:0] ma_i;
  logic [4:0]  ra_i;
  logic        video_o, h_sync_o, v_sync_o, de_o, underrun_o;

  video_pixel_out_if mif ();

  video_pixel_out dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .cclk_en_i  (cclk_en_i),
    .pixel_en_i (pixel_en_i),
    .de_i       (de_i),
    .h_sync_i   (h_sync_i),
    .v_sync_i   (v_sync_i),
    .ma_i       (ma_i),
    .ra_i       (ra_i),
    .graphic_i  (graphic_i),
    .mem        (mif),
    .video_o    (video_o),
    .h_sync_o   (h_sync_o),
    .v_sync_o   (v_sync_o),
    .de_o       (de_o),
    .underrun_o (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad   = 0;
  int          phase = 0;
  int          vcnt  = 0;
  int          rcnt  = 0;
  logic [7:0]  code_v, row_v;
  bit          rom_hold;
  // per-character observations
  logic [7:0]  vbyte;
  bit          vreq_seen, rreq_seen;
  logic [13:0] vaddr_seen;
  logic [10:0] raddr_seen;
  int          under_cnt;
  logic        hs1, vs1, de1, hs_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int idx;
    @(posedge clk_i);
    #1;
    if (mif.vram_req) begin
      vcnt++; vreq_seen = 1'b1; vaddr_seen = mif.vram_addr;
    end else vcnt = 0;
    mif.vram_valid = (vcnt == 2);
    mif.vram_data  = code_v;
    if (mif.rom_req) begin
      rcnt++; rreq_seen = 1'b1; raddr_seen = mif.rom_addr;
    end else rcnt = 0;
    mif.rom_valid = (rcnt == 2) && !rom_hold;
    mif.rom_data  = row_v;
    if (underrun_o) under_cnt++;
    phase = (phase + 1) % 16;
    if (phase % 2 == 1) begin
      idx = 7 - (phase - 1) / 2;
      vbyte[idx] = video_o;
    end
    if (phase == 1) begin
      hs1 = h_sync_o; vs1 = v_sync_o; de1 = de_o;
    end
    cclk_en_i  = (phase == 0);
    pixel_en_i = (phase % 2 == 0);
  endtask

  task automatic set_cell(input logic de, input logic hs, input logic vs, input logic [13:0] ma,
                          input logic [4:0] ra, input logic [7:0] code, input logic [7:0] row,
                          input bit hold);
    de_i = de; h_sync_i = hs; v_sync_i = vs; ma_i = ma; ra_i = ra; graphic_i = 1'b0;
    code_v = code; row_v = row; rom_hold = hold;
    vbyte = 8'hxx; vreq_seen = 0; rreq_seen = 0; vaddr_seen = '0; raddr_seen = '0; under_cnt = 0;
  endtask

  task automatic run_char(input logic de, input logic hs, input logic vs, input logic [13:0] ma,
                          input logic [4:0] ra, input logic [7:0] code, input logic [7:0] row,
                          input bit hold);
    set_cell(de, hs, vs, ma, ra, code, row, hold);
    repeat (16) cyc();
    hs_end = h_sync_o;
  endtask

  initial begin
    reset_i = 1'b1;
    cclk_en_i = 0; pixel_en_i = 0;
    mif.vram_valid = 0; mif.vram_data = '0; mif.rom_valid = 0; mif.rom_data = '0;
    set_cell(0, 0, 0, '0, '0, 8'h00, 8'h00, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_video", video_o, 0);
    check("rst_hsync", h_sync_o, 0);
    check("rst_vsync", v_sync_o, 0);
    check("rst_de", de_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_vram_req", mif.vram_req, 0);
    check("rst_rom_req", mif.rom_req, 0);
    check("rst_rom_addr", mif.rom_addr, 0);
    reset_i = 1'b0;
    phase = 15;
    cyc();

    // C1: code 0x01, ra 2
    run_char(1, 1, 0, 14'h0123, 5'd2, 8'h01, 8'h3C, 0);
    check("c1_vram_addr", vaddr_seen, 14'h0123);
    check("c1_rom_addr", raddr_seen, 11'h00A);
    check("c1_hsync_not_early", hs_end, 0);
    // C2: reverse code; shows C1
    run_char(1, 0, 1, 14'h0124, 5'd2, 8'h81, 8'h3C, 0);
    check("c2_pixels", vbyte, 8'h3C);
    check("c2_hsync", hs1, 1);
    check("c2_vsync", vs1, 0);
    check("c2_de", de1, 1);
    check("c2_rom_addr", raddr_seen, 11'h00A);
    // C3: spacing line reverse; shows C2
    run_char(1, 0, 0, 14'h0125, 5'd9, 8'h81, 8'h3C, 0);
    check("c3_pixels_rev", vbyte, 8'hC3);
    check("c3_vsync", vs1, 1);
    check("c3_no_rom_req", rreq_seen, 0);
    // C4: spacing line normal; shows C3
    run_char(1, 0, 0, 14'h0126, 5'd9, 8'h01, 8'h3C, 0);
    check("c4_pixels_space_rev", vbyte, 8'hFF);
    check("c4_no_rom_req", rreq_seen, 0);
    // C5: blanking; shows C4
    run_char(0, 1, 1, 14'h0127, 5'd2, 8'h01, 8'h3C, 0);
    check("c5_pixels_space", vbyte, 8'h00);
    check("c5_no_vram_req", vreq_seen, 0);
    check("c5_underrun", under_cnt, 0);
    // C6: glyph read withheld; shows C5
    run_char(1, 0, 0, 14'h0128, 5'd2, 8'h01, 8'h3C, 1);
    check("c6_pixels_blank", vbyte, 8'h00);
    check("c6_hsync", hs1, 1);
    check("c6_vsync", vs1, 1);
    check("c6_de", de1, 0);
    // C7: normal; shows the underrun cell
    run_char(1, 0, 0, 14'h0129, 5'd2, 8'h01, 8'h5A, 0);
    check("c7_underrun_once", under_cnt, 1);
    check("c7_pixels_underrun", vbyte, 8'h00);
    check("c7_de", de1, 1);
    // C8: shows C7
    run_char(0, 0, 0, 14'h012A, 5'd2, 8'h01, 8'h00, 0);
    check("c8_pixels_recover", vbyte, 8'h5A);
    check("c8_underrun", under_cnt, 0);

    // Reset in the middle of a glyph fetch
    set_cell(1, 0, 0, 14'h0200, 5'd2, 8'h01, 8'h3C, 1);
    repeat (4) cyc();
    check("pre_rst_rom_req", mif.rom_req, 1);
    #2 reset_i = 1'b1;
    #1;
    check("rst_async_rom_req", mif.rom_req, 0);
    check("rst_async_vram_req", mif.vram_req, 0);
    cclk_en_i = 0; pixel_en_i = 0;
    @(posedge clk_i); @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check("post_rst_de", de_o, 0);
    check("post_rst_video", video_o, 0);
    check("post_rst_underrun", underrun_o, 0);
    check("post_rst_hsync", h_sync_o, 0);
    phase = 15;
    cyc();
    run_char(1, 1, 0, 14'h0300, 5'd2, 8'h01, 8'h3C, 0);
    check("c10_vram_addr", vaddr_seen, 14'h0300);
    check("c10_rom_addr", raddr_seen, 11'h00A);
    check("c10_underrun", under_cnt, 0);
    run_char(0, 0, 0, 14'h0301, 5'd2, 8'h00, 8'h00, 0);
    check("c11_pixels", vbyte, 8'h3C);
    check("c11_hsync", hs1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
